direction_input_latch: RTL
==========================

// Module: direction_input_latch
// PURPOSE
// Turns raw active-low direction pushbuttons into a clean one-hot direction for the snake game logic.
// Synchronises and debounces each key, then holds the newest legal request as pending. Rejects 180-degree reversals.
// Commits the pending request only on the game tick, so direction changes once per move.
// Sits between the board KEY pins and the dirIn input of the snake logic / food blocks.
// PARAMETERS
// DEBOUNCE_CYCLES  250000  clk cycles a key must be stable before a level change is accepted (>=2)
// CNT_W            18      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
// clk              in   1  system clock (50 MHz)
// reset_n          in   1  synchronous, active-low reset
// key_n            in   4  raw pushbuttons, active-low, asynchronous; [0]=right [1]=up [2]=down [3]=left
// tick             in   1  game tick, one-clk pulse from the game rate divider
// dir_out          out  4  committed direction, one-hot, same bit map as key_n
// pending_valid    out  1  a legal request is waiting for the next tick
// dir_changed      out  1  one-clk pulse: dir_out took a new value at the previous edge
// reverse_rejected out  1  one-clk pulse: a press opposite to dir_out was discarded
// BEHAVIOUR
// Reset (reset_n low at an edge):
//  - dir_out=4'b0001 (right); pending=0; pending_valid=0; dir_changed=0; reverse_rejected=0
//  - both sync stages=4'b0000 (released); stable=0; stable_d=0; all counters=0
// Sync: two flops per key on ~key_n (active-high); only sync2 is used downstream.
// Debounce, per key:
//  - while sync2!=stable, cnt increments
//  - when cnt==DEBOUNCE_CYCLES-1 and sync2!=stable: stable<=sync2, cnt<=0
//  - whenever sync2==stable: cnt<=0; glitches shorter than DEBOUNCE_CYCLES never change stable
// Press event: press=stable & ~stable_d (rising edge only); a held key produces exactly one event.
// Press select: one key per cycle by fixed priority right>up>down>left; lower-priority simultaneous presses are dropped.
// Latency: key sampled low at edge k -> stable set at edge k+1+D -> pending_valid high after edge k+2+D (D=DEBOUNCE_CYCLES).
// Opposites are right<->left and up<->down. ref_dir = value dir_out takes at this edge, i.e. pending if (tick && pending_valid), else dir_out.
// Per edge, with a selected press p:
//  - p opposite ref_dir: discard; reverse_rejected<=1; pending unchanged unless tick consumed it
//  - p==ref_dir: discard silently; no pulse
//  - otherwise: pending<=p; pending_valid<=1 (last press wins; overwrites any older pending)
// On tick with pending_valid=1:
//  - dir_out<=pending; pending_valid<=0, unless a legal press is stored at the same edge
//  - dir_changed<=1
// tick with pending_valid=0: no change; no pulse.
// Simultaneous tick and press: the tick commits first, then the press is checked against the new dir_out and may become the next pending.
// Pulses are registered, high for exactly one clk; dir_out is never 0 and never multi-hot.
// Reset mid-debounce or mid-pending: everything returns to reset values.
//  - A key held through reset release re-debounces from released and yields one press event.
// TESTING (DEBOUNCE_CYCLES=4)
// 1. Reset, no keys, 10 ticks -> dir_out=0001 throughout; pending_valid, dir_changed, reverse_rejected stay 0.
// 2. key_n[1] low at edge 0, held -> pending_valid=1 after edge 6; tick at edge 9 -> dir_out=0010, dir_changed pulse after edge 9.
// 3. dir_out=0001, press left -> reverse_rejected single pulse, pending_valid stays 0, dir_out unchanged after tick.
// 4. key_n[2] glitch low 3 cycles then high -> no press event; pending_valid stays 0.
// 5. Press up, then down before the tick (both legal vs right) -> tick commits 0100; exactly one dir_changed pulse.
// 6. Pending=up, press left on the same edge as the tick -> dir_out=0010, then pending=1000, pending_valid=1; next tick -> 1000.
// 7. Hold key_n[0] and key_n[3] together from up -> only right is accepted; after the tick dir_out=0001.

Source files
------------

// File: rtl/direction_input_latch.sv
`default_nettype none
// ============================================================================
//  Module      : direction_input_latch
//  Description : Synchronises and debounces four active-low direction keys,
//                holds the newest legal request as pending, rejects
//                180-degree reversals and commits on the game tick.
//  Revision    : 1.0  initial release
// ============================================================================
module direction_input_latch #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key_n,
    input  logic       tick,
    output logic [3:0] dir_out,
    output logic       pending_valid,
    output logic       dir_changed,
    output logic       reverse_rejected
);

    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       c_dir_right = 4'b0001;

    // Synchroniser and debounce state
    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            stable_q, stable_d;
    logic [3:0]            stable_prev_q, stable_prev_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

    // Direction state
    logic [3:0] dir_q, dir_d;
    logic [3:0] pending_q, pending_d;
    logic       pending_valid_q, pending_valid_d;
    logic       dir_changed_q, dir_changed_d;
    logic       reverse_rejected_q, reverse_rejected_d;

    // Combinational helpers
    logic [3:0] press;
    logic [3:0] sel;
    logic [3:0] ref_dir;
    logic [3:0] opp_dir;
    logic       commit;
    logic       press_any;
    logic       is_reverse;
    logic       is_same;
    logic       is_legal;

    // Two-flop synchroniser on the inverted keys, then per-key debounce counters
    always_comb begin
        sync1_d       = ~key_n;
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        cnt_d         = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == c_cnt_max) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Pick one press per cycle (right > up > down > left) and classify it
    // against the direction that will be current after this edge
    always_comb begin
        press = stable_q & ~stable_prev_q;
        sel   = 4'b0000;
        if (press[0])      sel = 4'b0001;
        else if (press[1]) sel = 4'b0010;
        else if (press[2]) sel = 4'b0100;
        else if (press[3]) sel = 4'b1000;

        commit  = tick & pending_valid_q;
        ref_dir = commit ? pending_q : dir_q;
        // Bit map is right/up/down/left, so reversing the bit order gives the opposite
        opp_dir = {ref_dir[0], ref_dir[1], ref_dir[2], ref_dir[3]};

        press_any  = |sel;
        is_reverse = press_any && (sel == opp_dir);
        is_same    = press_any && (sel == ref_dir);
        is_legal   = press_any && !is_reverse && !is_same;
    end

    // Next-state for committed direction, pending request and event pulses
    always_comb begin
        dir_d              = commit ? pending_q : dir_q;
        dir_changed_d      = commit;
        reverse_rejected_d = is_reverse;
        pending_d          = pending_q;
        pending_valid_d    = pending_valid_q;
        if (is_legal) begin
            pending_d       = sel;
            pending_valid_d = 1'b1;
        end else if (commit) begin
            pending_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q            <= 4'b0000;
            sync2_q            <= 4'b0000;
            stable_q           <= 4'b0000;
            stable_prev_q      <= 4'b0000;
            cnt_q              <= '0;
            dir_q              <= c_dir_right;
            pending_q          <= 4'b0000;
            pending_valid_q    <= 1'b0;
            dir_changed_q      <= 1'b0;
            reverse_rejected_q <= 1'b0;
        end else begin
            sync1_q            <= sync1_d;
            sync2_q            <= sync2_d;
            stable_q           <= stable_d;
            stable_prev_q      <= stable_prev_d;
            cnt_q              <= cnt_d;
            dir_q              <= dir_d;
            pending_q          <= pending_d;
            pending_valid_q    <= pending_valid_d;
            dir_changed_q      <= dir_changed_d;
            reverse_rejected_q <= reverse_rejected_d;
        end
    end

    assign dir_out          = dir_q;
    assign pending_valid    = pending_valid_q;
    assign dir_changed      = dir_changed_q;
    assign reverse_rejected = reverse_rejected_q;

endmodule
`default_nettype wire
